hilo_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit for the MIPS datapath.
- Owns the architectural HI and LO registers.
- Feeds the HI_MUX/LO_MUX read path that serves MFHI/MFLO.
- Executes MULT, MULTU, DIV, DIVU iteratively, one bit per cycle; performs MTHI/MTLO as single-cycle writes.
- Exposes busy so hazard logic can stall MFHI/MFLO and any new mult/div until the result is committed.

---
 rtl/hilo_muldiv_unit.sv | 202 ++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Iterative multiply/divide unit that owns the architectural HI/LO pair.
//   MULT/MULTU/DIV/DIVU take WIDTH+2 edges from the start edge to the commit
//   edge: one capture edge, WIDTH single-bit iterations, one sign-fix/commit
//   edge. MTHI/MTLO are single-cycle writes that only happen while idle.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; aborts any in-flight operation
//   start        request, sampled only while busy=0
//   op[2:0]      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//                11x no-op
//   rs_val       operand A / dividend / MTHI-MTLO source
//   rt_val       operand B / divisor
//   HI, LO       architectural registers, feed the MFHI/MFLO read muxes
//   busy         mult/div in progress (state != IDLE)
//   done         one-cycle pulse in the cycle after HI/LO are committed
//   dbg_state_o  current FSM state (0 IDLE, 1 RUN, 2 FINISH)
//
// Handshake: start is a level sampled at a rising edge only when busy=0;
// there is no ready/ack. A request seen while busy=1 is dropped, so the
// issuing pipeline must hold off until busy=0 (which includes the done cycle).
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  // work_q holds {partial product} or {remainder, quotient/dividend}
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;       // product/quotient must be negated
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q, div0_d;

  logic               is_signed;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      work_q    <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      work_q    <= work_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !op[2]) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FINISH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = done_q;
    HI          = hi_q;
    LO          = lo_q;
    dbg_state_o = state_q;
  end

  // ---------------- datapath ----------------
  // Signed ops are only the even encodings (MULT, DIV).
  assign is_signed = ~op[0];
  assign rs_mag    = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_mag    = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier bit (LSB) is set, then shift the whole register right by one,
  // keeping the carry.
  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                  + (work_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

  // Restoring divide: shift next dividend bit into the remainder and try the
  // subtraction. The remainder is always below the divisor, so WIDTH+1 bits
  // suffice for the shifted value. A zero divisor naturally yields an
  // all-ones quotient and leaves the dividend magnitude as remainder.
  assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[WIDTH]
                   ? {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  work_q[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q ? -work_q : work_q;
  assign quo_fix  = neg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
  // With a zero divisor the remainder is |rs|; re-applying the dividend sign
  // restores rs exactly, including the most negative value.
  assign rem_fix  = rem_neg_q ? -work_q[2*WIDTH-1:WIDTH]
                              : work_q[2*WIDTH-1:WIDTH];

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    work_d    = work_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!op[2]) begin
            // Same initial layout for both: upper half zero, rs magnitude low.
            work_d    = {{WIDTH{1'b0}}, rs_mag};
            opnd_d    = rt_mag;
            is_div_d  = op[1];
            neg_d     = is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            rem_neg_d = is_signed && rs_val[WIDTH-1];
            div0_d    = (rt_val == '0);
          end else if (!op[1]) begin
            if (op[0]) lo_d = rs_val;
            else       hi_d = rs_val;
          end
        end
      end
      S_RUN: work_d = is_div_q ? div_next : mul_next;
      S_FINISH: begin
        done_d = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = div0_q ? '1 : quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: driver tasks issue operations and push
// the hand-computed {HI,LO} into exp_q; a monitor pops on every done pulse.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs_val, rt_val;
  logic [W-1:0] HI, LO;
  logic         busy, done;
  logic [1:0]   dbg_state;

  logic [2*W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  logic [W-1:0] hi_m, lo_m;   // bench's view of HI/LO

  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .HI(HI), .LO(LO),
    .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("result_hi", HI, e[2*W-1:W]);
        check("result_lo", LO, e[W-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic run_md(input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp);
    int n;
    exp_q.push_back(exp);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    // operands change after capture; result must not care
    rs_val = $urandom; rt_val = $urandom; op = 3'($urandom_range(0, 7));
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("busy_cycles", n, 33);
    hi_m = exp[2*W-1:W];
    lo_m = exp[W-1:0];
  endtask

  task automatic mt_write(input logic [2:0] o, input logic [W-1:0] v);
    start = 1'b1; op = o; rs_val = v; rt_val = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    if (o == OP_MTHI) hi_m = v;
    else              lo_m = v;
    check("mt_hi", HI, hi_m);
    check("mt_lo", LO, lo_m);
    check("mt_busy", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1; start = 1'b0; op = 3'b0; rs_val = '0; rt_val = '0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);

    run_md(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_md(OP_MULT,  32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB);
    run_md(OP_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD);
    run_md(OP_DIVU,  32'd7,        32'd2,        64'h00000001_00000003);
    run_md(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_md(OP_DIVU,  32'h00001234, 32'd0,        64'h00001234_FFFFFFFF);
    run_md(OP_DIV,   32'hFFFFFFF9, 32'd0,        64'hFFFFFFF9_FFFFFFFF);
    run_md(OP_DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    run_md(OP_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 64'h00000000_0000001E);
    run_md(OP_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000);

    // idle MTLO: HI keeps the last product's high word
    mt_write(OP_MTLO, 32'hDEADBEEF);
    mt_write(OP_MTHI, 32'h0BADF00D);

    // MTHI while a MULT runs must be dropped
    exp_q.push_back(64'h00000000_0000000C);
    start = 1'b1; op = OP_MULT; rs_val = 32'd3; rt_val = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    repeat (5) begin n++; @(posedge clk); #1; end
    start = 1'b1; op = OP_MTHI; rs_val = 32'h1;
    n++; @(posedge clk); #1;
    start = 1'b0;
    check("mthi_busy_hi", HI, hi_m);
    check("mthi_busy_lo", LO, lo_m);
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("busy_cycles_mthi", n, 33);
    check("mthi_after_hi", HI, 0);
    hi_m = '0; lo_m = 32'hC;

    // 11x no-op
    start = 1'b1; op = 3'b110; rs_val = 32'h55555555; rt_val = 32'h3;
    @(posedge clk); #1;
    op = 3'b111;
    @(posedge clk); #1;
    start = 1'b0;
    check("nop_busy", busy, 0);
    check("nop_hi", HI, hi_m);
    check("nop_lo", LO, lo_m);

    // reset during busy cycle 10: no partial result, no done
    start = 1'b1; op = OP_MULT; rs_val = 32'd5; rt_val = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_hi", HI, 0);
    check("abort_lo", LO, 0);
    check("abort_busy", busy, 0);
    check("abort_state", dbg_state, 0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_idle_busy", busy, 0);
    run_md(OP_MULTU, 32'd5, 32'd6, 64'h00000000_0000001E);

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
